// File: rtl/ps2_pkg.sv
// Shared state encoding and PS/2 command/response bytes for the mouse host controller.
package ps2_pkg;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_SEND_CMD = 6'b000010,
        ST_WAIT_ACK = 6'b000100,
        ST_WAIT_BAT = 6'b001000,
        ST_STREAM   = 6'b010000,
        ST_FAIL     = 6'b100000
    } state_t;

    localparam int CMD_IDX_W = 4;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_DEV_ID   = 8'h00;

endpackage

// File: rtl/ps2_init_rom.sv
// Init command sequence: index -> command byte plus a flag marking the final command.
// The 4-byte variant prepends the 200/100/80 rate knock that unlocks the wheel.
module ps2_init_rom
    import ps2_pkg::*;
#(
    parameter int         PKT_BYTES   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic [CMD_IDX_W-1:0] cmd_idx,
    output logic [7:0]           cmd_byte,
    output logic                 cmd_last
);

    always_comb begin
        cmd_byte = CMD_RESET;
        cmd_last = 1'b0;
        if (PKT_BYTES == 4) begin
            case (cmd_idx)
                4'd0:    cmd_byte = CMD_RESET;
                4'd1:    cmd_byte = CMD_SET_RATE;
                4'd2:    cmd_byte = 8'hC8;
                4'd3:    cmd_byte = CMD_SET_RATE;
                4'd4:    cmd_byte = 8'h64;
                4'd5:    cmd_byte = CMD_SET_RATE;
                4'd6:    cmd_byte = 8'h50;
                4'd7:    cmd_byte = CMD_SET_RATE;
                4'd8:    cmd_byte = SAMPLE_RATE;
                4'd9: begin
                    cmd_byte = CMD_ENABLE;
                    cmd_last = 1'b1;
                end
                default: cmd_byte = CMD_RESET;
            endcase
        end else begin
            case (cmd_idx)
                4'd0:    cmd_byte = CMD_RESET;
                4'd1:    cmd_byte = CMD_SET_RATE;
                4'd2:    cmd_byte = SAMPLE_RATE;
                4'd3: begin
                    cmd_byte = CMD_ENABLE;
                    cmd_last = 1'b1;
                end
                default: cmd_byte = CMD_RESET;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host controller: init/retry sequencer and stream packet assembler.
// Optional macro PS2_PKT_SYNC_EN adds byte0 bit3 sync checking and a sync_err_cnt output.
module ps2_mouse_ctrl
    import ps2_pkg::*;
#(
    parameter int         PKT_BYTES   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter int         TIMEOUT_CYC = 25_000_000,
    parameter int         PKT_GAP_CYC = 100_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    output logic                   rd_en,
    input  logic                   rd_vld,
    input  logic [7:0]             rd_data,
    output logic                   wr_en,
    output logic [7:0]             wr_data,
    input  logic                   wr_done,
    output logic                   pkt_vld,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   init_done,
    output logic                   init_fail,
    output logic [1:0]             retry_cnt,
`ifdef PS2_PKT_SYNC_EN
    output logic [7:0]             sync_err_cnt,
`endif
    output logic [5:0]             current_state
);

    localparam int               PKT_W      = 8 * PKT_BYTES;
    localparam int               TMR_W      = 32;
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(PKT_GAP_CYC - 1);
    localparam logic [1:0]       LAST_SLOT  = 2'(PKT_BYTES - 1);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY - 1);

    state_t               state, state_n;
    logic [CMD_IDX_W-1:0] cmd_idx, cmd_idx_n;
    logic [1:0]           retry_n;
    logic [TMR_W-1:0]     timer;
    logic                 bat_seen;
    logic                 cmd_sent;
    logic [1:0]           byte_cnt;
    logic [1:0]           slot;
    logic [PKT_W-1:0]     pkt_buf, pkt_asm;
    logic [7:0]           rom_byte;
    logic                 rom_last;
    logic                 timeout, gap_hit, drop, do_retry;

    ps2_init_rom #(
        .PKT_BYTES  (PKT_BYTES),
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_rom (
        .cmd_idx (cmd_idx),
        .cmd_byte(rom_byte),
        .cmd_last(rom_last)
    );

    assign timeout       = (timer == TMO_LAST);
    assign gap_hit       = (state == ST_STREAM) && (byte_cnt != 2'd0) && (timer == GAP_LAST);
    assign slot          = gap_hit ? 2'd0 : byte_cnt;
    assign rd_en         = (state != ST_SEND_CMD);
    assign init_done     = (state == ST_STREAM);
    assign init_fail     = (state == ST_FAIL);
    assign current_state = state;

    always_comb begin
        pkt_asm = pkt_buf;
        for (int b = 0; b < PKT_BYTES; b++) begin
            if (slot == 2'(b)) pkt_asm[8*b +: 8] = rd_data;
        end
    end

    always_comb begin
        state_n   = state;
        cmd_idx_n = cmd_idx;
        retry_n   = retry_cnt;
        do_retry  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_vld || timeout) begin
                    state_n   = ST_SEND_CMD;
                    cmd_idx_n = '0;
                end
            end
            ST_SEND_CMD: begin
                if (wr_done) state_n = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rd_vld) begin
                    if (rd_data == RSP_ACK) begin
                        if (cmd_idx == '0) begin
                            state_n = ST_WAIT_BAT;
                        end else if (rom_last) begin
                            state_n = ST_STREAM;
                        end else begin
                            cmd_idx_n = cmd_idx + 4'd1;
                            state_n   = ST_SEND_CMD;
                        end
                    end else if (rd_data == RSP_RESEND) begin
                        state_n = ST_SEND_CMD;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                // BAT result first, then the device ID; anything out of order restarts
                if (rd_vld) begin
                    if (!bat_seen && rd_data == RSP_BAT_OK) begin
                        state_n = ST_WAIT_BAT;
                    end else if (bat_seen && rd_data == RSP_DEV_ID) begin
                        cmd_idx_n = 4'd1;
                        state_n   = ST_SEND_CMD;
                    end else begin
                        do_retry = 1'b1;
                    end
                end else if (timeout) begin
                    do_retry = 1'b1;
                end
            end
            ST_STREAM: state_n = ST_STREAM;
            ST_FAIL:   state_n = ST_FAIL;
            default:   state_n = ST_IDLE;
        endcase
        if (do_retry) begin
            if (retry_cnt == RETRY_LAST) begin
                state_n = ST_FAIL;
            end else begin
                retry_n   = retry_cnt + 2'd1;
                cmd_idx_n = '0;
                state_n   = ST_SEND_CMD;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_idx   <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            bat_seen  <= 1'b0;
            cmd_sent  <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= 8'h00;
            byte_cnt  <= '0;
            pkt_buf   <= '0;
            pkt_data  <= '0;
            pkt_vld   <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_idx   <= cmd_idx_n;
            retry_cnt <= retry_n;

            if (state_n != state || rd_vld) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TMR_W'(1);
            end

            if (state != ST_WAIT_BAT) begin
                bat_seen <= 1'b0;
            end else if (rd_vld && !bat_seen && rd_data == RSP_BAT_OK) begin
                bat_seen <= 1'b1;
            end

            // one transmit request per visit to SEND_CMD, issued on its first cycle
            wr_en    <= 1'b0;
            cmd_sent <= (state == ST_SEND_CMD) && (state_n == ST_SEND_CMD);
            if (state == ST_SEND_CMD && !cmd_sent) begin
                wr_en   <= 1'b1;
                wr_data <= rom_byte;
            end

            pkt_vld <= 1'b0;
            if (state == ST_STREAM) begin
                if (rd_vld && !drop) begin
                    pkt_buf <= pkt_asm;
                    if (slot == LAST_SLOT) begin
                        byte_cnt <= '0;
                        pkt_vld  <= 1'b1;
                        pkt_data <= pkt_asm;
                    end else begin
                        byte_cnt <= slot + 2'd1;
                    end
                end else if (gap_hit || rd_vld) begin
                    byte_cnt <= '0;
                end
            end
        end
    end

`ifdef PS2_PKT_SYNC_EN
    assign drop = (state == ST_STREAM) && (slot == 2'd0) && !rd_data[3];

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync_err_cnt <= '0;
        end else if (rd_vld && drop && sync_err_cnt != 8'hFF) begin
            sync_err_cnt <= sync_err_cnt + 8'd1;
        end
    end
`else
    assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: one 3-byte and one 4-byte instance, scoreboard on wr_data and packets.
module tb_ps2_mouse_ctrl;

    localparam int TMO = 300;
    localparam int GAP = 40;

    typedef struct packed {
        logic        inst;
        logic [31:0] val;
    } exp_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [1:0]       rst_n;
    logic [1:0]       rd_vld;
    logic [1:0][7:0]  rd_data;
    logic [1:0]       wr_done;
    logic [1:0]       rd_en_w, wr_en_w, pkt_vld_w, init_done_w, init_fail_w;
    logic [1:0][7:0]  wr_data_w;
    logic [1:0][1:0]  retry_w;
    logic [1:0][5:0]  state_w;
    logic [23:0]      pkt3;
    logic [31:0]      pkt4;
`ifdef PS2_PKT_SYNC_EN
    logic [1:0][7:0]  sync_w;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t wr_q[$];
    exp_t pkt_q[$];
    exp_t mon_e;

    ps2_mouse_ctrl #(.PKT_BYTES(3), .SAMPLE_RATE(8'd100), .TIMEOUT_CYC(TMO),
                     .PKT_GAP_CYC(GAP), .MAX_RETRY(3)) u3 (
        .clk_sys(clk_sys), .rst_n(rst_n[0]), .rd_en(rd_en_w[0]), .rd_vld(rd_vld[0]),
        .rd_data(rd_data[0]), .wr_en(wr_en_w[0]), .wr_data(wr_data_w[0]), .wr_done(wr_done[0]),
        .pkt_vld(pkt_vld_w[0]), .pkt_data(pkt3), .init_done(init_done_w[0]),
        .init_fail(init_fail_w[0]), .retry_cnt(retry_w[0]),
`ifdef PS2_PKT_SYNC_EN
        .sync_err_cnt(sync_w[0]),
`endif
        .current_state(state_w[0]));

    ps2_mouse_ctrl #(.PKT_BYTES(4), .SAMPLE_RATE(8'd100), .TIMEOUT_CYC(TMO),
                     .PKT_GAP_CYC(GAP), .MAX_RETRY(3)) u4 (
        .clk_sys(clk_sys), .rst_n(rst_n[1]), .rd_en(rd_en_w[1]), .rd_vld(rd_vld[1]),
        .rd_data(rd_data[1]), .wr_en(wr_en_w[1]), .wr_data(wr_data_w[1]), .wr_done(wr_done[1]),
        .pkt_vld(pkt_vld_w[1]), .pkt_data(pkt4), .init_done(init_done_w[1]),
        .init_fail(init_fail_w[1]), .retry_cnt(retry_w[1]),
`ifdef PS2_PKT_SYNC_EN
        .sync_err_cnt(sync_w[1]),
`endif
        .current_state(state_w[1]));

    function automatic logic [31:0] pkt_of(input int i);
        return (i == 0) ? {8'h00, pkt3} : pkt4;
    endfunction

    function automatic logic [7:0] cmd_of(input int i, input int k);
        logic [7:0] c3 [4];
        logic [7:0] c4 [10];
        c3 = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
        c4 = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF3, 8'h64, 8'hF4};
        if (i == 0) return c3[k];
        return c4[k];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_pkt, input int i, input logic [31:0] v);
        exp_t e;
        e.inst = i[0];
        e.val  = v;
        if (is_pkt) pkt_q.push_back(e);
        else        wr_q.push_back(e);
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        @(posedge clk_sys); #1;
        rd_data[i] = b;
        rd_vld[i]  = 1'b1;
        @(posedge clk_sys); #1;
        rd_vld[i]  = 1'b0;
    endtask

    // wait (bounded) for a transmit request, then acknowledge it like ps2_tx would
    task automatic tx_cycle(input int i, input int limit, output int waited);
        waited = 0;
        @(negedge clk_sys);
        while (!wr_en_w[i] && waited < limit) begin
            @(negedge clk_sys);
            waited++;
        end
        total++;
        if (!wr_en_w[i]) begin
            bad++;
            $display("FAIL u%0d wr_en wait: got no pulse, expected one within %0d cycles", i, limit);
        end else begin
            @(posedge clk_sys); #1 wr_done[i] = 1'b1;
            @(posedge clk_sys); #1 wr_done[i] = 1'b0;
        end
    endtask

    task automatic reset_inst(input int i);
        @(posedge clk_sys); #1 rst_n[i] = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 rst_n[i] = 1'b1;
    endtask

    task automatic check_reset_vals(input int i);
        chk($sformatf("u%0d rst state", i), {26'd0, state_w[i]}, 32'h01);
        chk($sformatf("u%0d rst rd_en", i), {31'd0, rd_en_w[i]}, 32'd1);
        chk($sformatf("u%0d rst wr_en", i), {31'd0, wr_en_w[i]}, 32'd0);
        chk($sformatf("u%0d rst wr_data", i), {24'd0, wr_data_w[i]}, 32'd0);
        chk($sformatf("u%0d rst pkt_vld", i), {31'd0, pkt_vld_w[i]}, 32'd0);
        chk($sformatf("u%0d rst pkt_data", i), pkt_of(i), 32'd0);
        chk($sformatf("u%0d rst init_done", i), {31'd0, init_done_w[i]}, 32'd0);
        chk($sformatf("u%0d rst init_fail", i), {31'd0, init_fail_w[i]}, 32'd0);
        chk($sformatf("u%0d rst retry_cnt", i), {30'd0, retry_w[i]}, 32'd0);
    endtask

    task automatic run_init(input int i, input int fe_idx);
        int n, w;
        n = (i == 0) ? 4 : 10;
        for (int k = 0; k < n; k++) begin
            push(1'b0, i, {24'd0, cmd_of(i, k)});
            if (k == fe_idx) push(1'b0, i, {24'd0, cmd_of(i, k)});
        end
        send_byte(i, 8'hAA);
        for (int k = 0; k < n; k++) begin
            tx_cycle(i, 40, w);
            if (k == fe_idx) begin
                send_byte(i, 8'hFE);
                tx_cycle(i, 40, w);
            end
            send_byte(i, 8'hFA);
            if (k == 0) begin
                send_byte(i, 8'hAA);
                send_byte(i, 8'h00);
            end
        end
        @(negedge clk_sys);
        chk($sformatf("u%0d init_done", i), {31'd0, init_done_w[i]}, 32'd1);
        chk($sformatf("u%0d stream state", i), {26'd0, state_w[i]}, 32'h10);
        chk($sformatf("u%0d init retry_cnt", i), {30'd0, retry_w[i]}, 32'd0);
        chk($sformatf("u%0d stream rd_en", i), {31'd0, rd_en_w[i]}, 32'd1);
    endtask

    always @(negedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en_w[i]) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL u%0d wr_data: got %02h with nothing expected", i, wr_data_w[i]);
                end else begin
                    mon_e = wr_q.pop_front();
                    if (mon_e.inst != i[0] || mon_e.val[7:0] != wr_data_w[i]) begin
                        bad++;
                        $display("FAIL u%0d wr_data: got %02h expected u%0d %02h",
                                 i, wr_data_w[i], mon_e.inst, mon_e.val[7:0]);
                    end
                end
            end
            if (pkt_vld_w[i]) begin
                total++;
                if (pkt_q.size() == 0) begin
                    bad++;
                    $display("FAIL u%0d pkt_data: got %08h with nothing expected", i, pkt_of(i));
                end else begin
                    mon_e = pkt_q.pop_front();
                    if (mon_e.inst != i[0] || mon_e.val != pkt_of(i)) begin
                        bad++;
                        $display("FAIL u%0d pkt_data: got %08h expected u%0d %08h",
                                 i, pkt_of(i), mon_e.inst, mon_e.val);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n   = 2'b00;
        rd_vld  = 2'b00;
        rd_data = '0;
        wr_done = 2'b00;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_vals(0);
        check_reset_vals(1);

        // 3-byte instance: init, then stream with a gap that drops a partial packet
        #1 rst_n[0] = 1'b1;
        run_init(0, -1);
        push(1'b1, 0, 32'h0002_0108);
        send_byte(0, 8'h09);
        send_byte(0, 8'h10);
        repeat (GAP + 10) @(posedge clk_sys);
        send_byte(0, 8'h08);
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        push(1'b1, 0, 32'h0080_FF0A);
        send_byte(0, 8'h0A);
        send_byte(0, 8'hFF);
        send_byte(0, 8'h80);
        repeat (4) @(posedge clk_sys);

        // 3-byte instance: silent mouse, three FF attempts then sticky FAIL
        reset_inst(0);
        repeat (3) push(1'b0, 0, 32'h0000_00FF);
        send_byte(0, 8'hAA);
        tx_cycle(0, 40, w);
        tx_cycle(0, TMO + 50, w);
        total++;
        if (w < TMO - 5 || w > TMO + 10) begin
            bad++;
            $display("FAIL retry spacing: got %0d cycles expected about %0d", w, TMO);
        end
        chk("u0 retry_cnt after 1st timeout", {30'd0, retry_w[0]}, 32'd1);
        tx_cycle(0, TMO + 50, w);
        chk("u0 retry_cnt after 2nd timeout", {30'd0, retry_w[0]}, 32'd2);
        repeat (TMO + 20) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("u0 init_fail", {31'd0, init_fail_w[0]}, 32'd1);
        chk("u0 fail state", {26'd0, state_w[0]}, 32'h20);
        chk("u0 fail init_done", {31'd0, init_done_w[0]}, 32'd0);
        send_byte(0, 8'hFA);
        send_byte(0, 8'hAA);
        repeat (TMO + 20) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("u0 fail sticky", {26'd0, state_w[0]}, 32'h20);

        // 4-byte instance: unlock sequence with one FE resend, then a wheel packet
        #1 rst_n[1] = 1'b1;
        run_init(1, 1);
        push(1'b1, 1, 32'h01FB_0508);
        send_byte(1, 8'h08);
        send_byte(1, 8'h05);
        send_byte(1, 8'hFB);
        send_byte(1, 8'h01);
        repeat (4) @(posedge clk_sys);

        // reset while waiting for an ACK
        reset_inst(1);
        push(1'b0, 1, 32'h0000_00FF);
        send_byte(1, 8'hAA);
        tx_cycle(1, 40, w);
        @(negedge clk_sys);
        chk("u1 wait_ack state", {26'd0, state_w[1]}, 32'h04);
        @(posedge clk_sys); #1 rst_n[1] = 1'b0;
        @(posedge clk_sys); #1;
        check_reset_vals(1);
        rst_n[1] = 1'b1;

        // bad ACK byte, then BAT bytes out of order: each charges one retry
        push(1'b0, 1, 32'h0000_00FF);
        send_byte(1, 8'hAA);
        tx_cycle(1, 40, w);
        push(1'b0, 1, 32'h0000_00FF);
        send_byte(1, 8'h55);
        tx_cycle(1, 40, w);
        chk("u1 retry after bad ack", {30'd0, retry_w[1]}, 32'd1);
        push(1'b0, 1, 32'h0000_00FF);
        send_byte(1, 8'hFA);
        send_byte(1, 8'h00);
        tx_cycle(1, 40, w);
        chk("u1 retry after bad bat", {30'd0, retry_w[1]}, 32'd2);
        @(negedge clk_sys);
        chk("u1 state after bad bat", {26'd0, state_w[1]}, 32'h04);
        #1 rst_n[1] = 1'b0;

        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("wr queue drained", wr_q.size(), 32'd0);
        chk("pkt queue drained", pkt_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
Next-generation PS/2 mouse host controller. It sits between ps2_rx/ps2_tx and the seven-segment/cursor logic.
- Runs a parametrised init sequence: reset, BAT wait, optional IntelliMouse unlock, sample rate, enable reporting.
- Adds a timeout/retry engine with a sticky failure state.
- Assembles 3- or 4-byte stream packets, with gap-based resynchronisation.

Parameters:
PKT_BYTES, 3, stream packet length; legal values 3 (standard) or 4 (IntelliMouse, wheel byte)
SAMPLE_RATE, 8'd100, byte sent after the final F3 command
TIMEOUT_CYC, 25_000_000, max cycles waiting for any response byte (0.5 s at 50 MHz)
PKT_GAP_CYC, 100_000, max idle cycles between bytes inside one packet (2 ms)
MAX_RETRY, 3, full-sequence restarts allowed before FAIL

Ports:
clk_sys  in  1  system clock (50 MHz); single clock domain
rst_n  in  1  synchronous active-low reset, sampled on posedge clk_sys
rd_en  out  1  ps2_rx enable
rd_vld  in  1  one-cycle strobe, rd_data valid
rd_data  in  8  received byte
wr_en  out  1  one-cycle pulse, start ps2_tx transmit
wr_data  out  8  byte to transmit
wr_done  in  1  one-cycle strobe, transmit complete
pkt_vld  out  1  one-cycle pulse, pkt_data updated
pkt_data  out  8*PKT_BYTES  byte0 at [7:0], byte n at [8n+7:8n]
init_done  out  1  high while in STREAM
init_fail  out  1  high while in FAIL
retry_cnt  out  2  full-sequence restarts so far
current_state  out  6  one-hot state, debug

Behaviour:
- Reset values (synchronous, rst_n=0 at posedge): state IDLE; wr_en=0; wr_data=8'h00; rd_en=1; pkt_vld=0; pkt_data=0; init_done=0; init_fail=0; retry_cnt=0; cmd_idx=0; byte_cnt=0; timer=0. Reset mid-transmit abandons the sequence; no partial state survives.
- Command ROM, every byte expects ACK FA:
  - PKT_BYTES=3: FF, F3, SAMPLE_RATE, F4.
  - PKT_BYTES=4: FF, F3, C8, F3, 64, F3, 50, F3, SAMPLE_RATE, F4.
- States: IDLE 000001, SEND_CMD 000010, WAIT_ACK 000100, WAIT_BAT 001000, STREAM 010000, FAIL 100000.
- IDLE: rd_vld (any byte) or timer==TIMEOUT_CYC-1 -> SEND_CMD, cmd_idx=0.
- SEND_CMD:
  - wr_en pulses exactly once, the cycle after entry; wr_data=ROM[cmd_idx] on that cycle.
  - rd_en=0 throughout SEND_CMD.
  - wr_done -> WAIT_ACK, timer cleared.
- WAIT_ACK, response FA:
  - cmd_idx==0 -> WAIT_BAT.
  - Last index -> STREAM.
  - Otherwise cmd_idx++ -> SEND_CMD.
- WAIT_ACK, other responses:
  - FE (resend) -> SEND_CMD, same cmd_idx, no retry charged.
  - Any other byte, or timeout -> RETRY.
- WAIT_BAT: expects AA then 00 (device ID), in order.
  - After 00: cmd_idx=1 -> SEND_CMD.
  - Wrong byte or timeout -> RETRY.
- RETRY (action, not a state):
  - retry_cnt==MAX_RETRY-1 -> FAIL.
  - Else retry_cnt++, cmd_idx=0 -> SEND_CMD.
- Timer: cleared on state change and on every rd_vld; saturates. FAIL is sticky until reset.
- STREAM capture:
  - Each rd_vld stores rd_data into slot byte_cnt; byte_cnt wraps at PKT_BYTES-1 -> 0.
  - pkt_vld is high the cycle after the last byte is stored, with pkt_data complete.
- STREAM gap: byte_cnt!=0 and idle for PKT_GAP_CYC -> byte_cnt=0, partial packet discarded, no pulse.
- Simultaneous events: rd_vld in the same cycle as gap expiry -> the byte is stored as byte 0. wr_done outside SEND_CMD is ignored; rd_vld in SEND_CMD is ignored.

Optional Feature:
PS2_PKT_SYNC_EN:
- Defined: in STREAM, a byte0 candidate with bit3==0 is dropped; byte_cnt stays 0 and sync_err_cnt (extra 8-bit output, saturating) increments.
- Undefined: no bit3 check, no sync_err_cnt port, first byte after gap/wrap is always byte0.

Decomposition:
- ps2_pkg: state one-hot localparams; constants CMD_RESET FF, CMD_SET_RATE F3, CMD_ENABLE F4, RSP_ACK FA, RSP_RESEND FE, RSP_BAT_OK AA, RSP_DEV_ID 00.
- Sub-module ps2_init_rom: combinational cmd_idx -> byte plus last flag, parametrised by PKT_BYTES and SAMPLE_RATE.

Test Plan:
- PKT_BYTES=3, mouse sends AA, then answers FA to each command, with AA,00 after the first -> wr_data sequence FF,F3,64,F4; init_done=1 after the fourth FA.
- PKT_BYTES=4, full ACKs -> ten commands FF,F3,C8,F3,64,F3,50,F3,64,F4 in order; then bytes 08,05,FB,01 -> single pkt_vld with pkt_data=32'h01FB0508.
- FE reply to the F3 at cmd_idx=1 -> F3 retransmitted, retry_cnt stays 0, sequence completes.
- No response after FF, MAX_RETRY=3 -> three FF transmissions each ~TIMEOUT_CYC apart, then init_fail=1, state FAIL; further rd_vld ignored.
- STREAM: bytes 09,10, gap of PKT_GAP_CYC+1 cycles, then 08,01,02 -> one pkt_vld, pkt_data=24'h020108.
- rst_n low during WAIT_ACK -> next cycle all outputs at reset values, state IDLE.
